esp8266_frame_serializer: RTL

//  Downstream of the lighthouse decoder array: takes one 256-bit sensor frame (8 x 32-bit decoded sensor words)
//  and streams it byte-wise into the 8-bit spi_master write port as an ESP8266 SPI-slave write transaction.

---
 rtl/esp8266_frame_serializer.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/esp8266_frame_serializer.sv
// Streams a latched 256-bit sensor frame into spi_master as an ESP8266 SPI-slave write:
// command byte, address byte, FRAME_BYTES payload bytes (LSB byte first). Optional CRC-8 trailer: `CRC8_TRAILER_EN.
module esp8266_frame_serializer #(
  parameter logic [7:0] CMD_BYTE    = 8'h02,
  parameter logic [7:0] ADDR_BYTE   = 8'h00,
  parameter int         FRAME_BYTES = 32
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic [255:0] data,
  input  logic         dataReady,
  input  logic         di_req,
  input  logic         write_ack,
  output logic [7:0]   data_byte,
  output logic         wren,
  output logic         busy,
  output logic         frame_done,
  output logic         overrun
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_WAIT_ACK,
    S_WAIT_REQ,
    S_DONE
  } state_t;

  localparam logic [5:0] PAY_LAST = 6'(FRAME_BYTES + 1);
`ifdef CRC8_TRAILER_EN
  localparam logic [5:0] LAST_IDX = 6'(FRAME_BYTES + 2);
`else
  localparam logic [5:0] LAST_IDX = PAY_LAST;
`endif

  state_t         state_q, state_d;
  logic [5:0]     idx_q, idx_d;
  logic [255:0]   frame_q, frame_d;
  logic [7:0]     byte_q, byte_d;
  logic           wren_q, wren_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           ovr_q, ovr_d;
  logic           req_q;
  logic [4:0]     pidx;
  logic [7:0]     cur_byte;

`ifdef CRC8_TRAILER_EN
  logic [7:0]     crc_q, crc_d;

  // CRC-8, poly 0x07, MSB-first, no reflection, no final XOR
  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic [7:0] b);
    logic [7:0] c;
    c = crc ^ b;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    end
    return c;
  endfunction
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      frame_q <= '0;
      byte_q  <= '0;
      wren_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
      req_q   <= 1'b0;
`ifdef CRC8_TRAILER_EN
      crc_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      frame_q <= frame_d;
      byte_q  <= byte_d;
      wren_q  <= wren_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
      req_q   <= di_req;
`ifdef CRC8_TRAILER_EN
      crc_q   <= crc_d;
`endif
    end
  end

  // Payload byte k sits at idx k+2; the 5-bit subtraction wraps correctly for idx 2..33
  always_comb begin
    pidx = idx_q[4:0] - 5'd2;
    if (idx_q == 6'd0) begin
      cur_byte = CMD_BYTE;
    end else if (idx_q == 6'd1) begin
      cur_byte = ADDR_BYTE;
`ifdef CRC8_TRAILER_EN
    end else if (idx_q == LAST_IDX) begin
      cur_byte = crc_q;
`endif
    end else begin
      cur_byte = frame_q[{pidx, 3'b000} +: 8];
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    frame_d = frame_q;
    byte_d  = byte_q;
    wren_d  = wren_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    ovr_d   = ovr_q | (dataReady && (state_q != S_IDLE));
`ifdef CRC8_TRAILER_EN
    crc_d   = crc_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (dataReady) begin
          frame_d = data;
          busy_d  = 1'b1;
          idx_d   = '0;
`ifdef CRC8_TRAILER_EN
          crc_d   = '0;
`endif
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        byte_d  = cur_byte;
        wren_d  = 1'b1;
        state_d = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (write_ack) begin
          wren_d = 1'b0;
`ifdef CRC8_TRAILER_EN
          if (idx_q >= 6'd2 && idx_q <= PAY_LAST) begin
            crc_d = crc8_step(crc_q, byte_q);
          end
`endif
          // frame_done is raised on DONE entry so it appears one clock after the final ack
          if (idx_q == LAST_IDX) begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + 6'd1;
            state_d = S_WAIT_REQ;
          end
        end
      end
      S_WAIT_REQ: begin
        if (di_req && !req_q) begin
          state_d = S_WRITE;
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign data_byte  = byte_q;
  assign wren       = wren_q;
  assign busy       = busy_q;
  assign frame_done = done_q;
  assign overrun    = ovr_q;

endmodule
